bnn_neuron_seq: RTL and testbench
=================================

// Module: bnn_neuron_seq
// PURPOSE
//  Sequences the existing combinational bnn XNOR-popcount unit over a multi-word binary vector
//  to compute one binarized neuron: dot = 2*sum(popcount(xnor(a,b))) - 32*N, act = (dot >= thresh).
//  Sits between an operand source (register file / load stream) and the BNN result writeback.
//  Instantiates one bnn unit internally and accumulates its result over N beats.
// PARAMETERS
//  MAX_WORDS  16  max 32-bit words per vector; N range 0..MAX_WORDS
//  NW_W       $clog2(MAX_WORDS+1)  width of word-count fields (derived, not overridden)
//  ACC_W      $clog2(32*MAX_WORDS+1)  unsigned accumulator width (derived)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  start_i      in   1        start pulse; sampled only in IDLE
//  num_words_i  in   NW_W     N, sampled with start_i
//  thresh_i     in   ACC_W+2  signed threshold, sampled with start_i
//  abort_i      in   1        abandon current operation
//  op_valid_i   in   1        operand pair valid
//  op_ready_o   out  1        operand pair accepted when valid&ready
//  op_a_i       in   32       activation word
//  op_b_i       in   32       weight word
//  busy_o       out  1        high in RUN or DONE
//  res_valid_o  out  1        result valid; held until res_ready_i
//  res_ready_i  in   1        result consumer ready
//  res_dot_o    out  ACC_W+2  signed dot product
//  res_act_o    out  1        binarized activation (dot >= thresh)
//  res_cnt_o    out  ACC_W    raw accumulated popcount
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc=0, beat count=0, all outputs 0; N, thresh regs cleared.
//  FSM states IDLE, RUN, DONE:
//   IDLE: op_ready_o=0. start_i=1 -> latch N (num_words_i), thresh, clear acc and beat count;
//         N>=1 -> RUN; N==0 -> DONE with acc=0 (dot=0). N>MAX_WORDS saturates to MAX_WORDS.
//   RUN:  op_ready_o=1 combinationally. Each valid&ready beat: acc += popcount(~(a^b)) (0..32),
//         beat count++. Beat N (count == N-1 at handshake) -> DONE next cycle. No valid -> hold state.
//   DONE: res_valid_o=1; res_cnt_o=acc; res_dot_o = 2*acc - 32*N (signed, ACC_W+2 bits, no overflow
//         by construction); res_act_o = (res_dot_o >= thresh, signed compare). Outputs stable while
//         res_valid_o && !res_ready_i. res_ready_i=1 -> IDLE next cycle.
//  Latency: result valid the cycle after the Nth accepted beat; N==0: the cycle after start.
//  start_i in RUN/DONE ignored (no re-latch, no restart).
//  abort_i (any state, priority over all else): -> IDLE next cycle, acc/count cleared, res_valid_o=0,
//   any beat presented that cycle is not accumulated; in IDLE abort_i with start_i -> stays IDLE.
//  Result outputs are 0 outside DONE. busy_o = (state != IDLE).
//  Reset asserted mid-operation: immediate return to reset values; no partial result emitted.
//  Accumulator never wraps: ACC_W sized for 32*MAX_WORDS.
// TESTING
//  1 N=1, a=b=32'hFFFF_FFFF, thresh=0 -> one beat, res_cnt=32, dot=+32, act=1, valid 1 cycle after beat.
//  2 N=4, a=32'h0, b=32'hFFFF_FFFF all beats, thresh=-128 -> cnt=0, dot=-128, act=1; thresh=-127 -> act=0.
//  3 N=3 with op_valid gaps (valid 1,0,0,1,0,1), a^b=32'h0000_FFFF each -> cnt=48, dot=0; accepts exactly 3 beats.
//  4 N=0, start -> DONE next cycle, dot=0, act=(0>=thresh); res_ready held 0 for 5 cycles -> outputs stable, then IDLE.
//  5 N=MAX_WORDS=16 all-matching words -> cnt=512, dot=+512 (no overflow); start_i pulsed during RUN ignored.
//  6 abort_i after 2 of 4 beats, then rst_n pulled low mid-RUN on a fresh op -> IDLE, res_valid never asserts, cnt=0.

Source files
------------

// File: rtl/bnn_neuron_seq.sv
// Binarized neuron sequencer: streams N operand word pairs through one XNOR-popcount
// unit, accumulates the match count, and emits a signed dot product plus thresholded activation.

module bnn_xnor_popcount (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [5:0]  cnt
);

  logic [31:0] match;

  // NOTE: combinational blocks assign every output first and use blocking '=' so no latch is inferred.
  always_comb begin
    match = ~(a ^ b);
    cnt   = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(match[i]);
    end
  end

endmodule

module bnn_neuron_seq #(
  parameter  int MAX_WORDS = 16,
  localparam int NW_W      = $clog2(MAX_WORDS + 1),
  localparam int ACC_W     = $clog2(32 * MAX_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [NW_W-1:0]         num_words_i,
  input  logic signed [ACC_W+1:0] thresh_i,
  input  logic                    abort_i,
  input  logic                    op_valid_i,
  output logic                    op_ready_o,
  input  logic [31:0]             op_a_i,
  input  logic [31:0]             op_b_i,
  output logic                    busy_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic signed [ACC_W+1:0] res_dot_o,
  output logic                    res_act_o,
  output logic [ACC_W-1:0]        res_cnt_o
);

  localparam int DOT_W = ACC_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [ACC_W-1:0]         acc;
  logic [NW_W-1:0]          beat_cnt;
  logic [NW_W-1:0]          n_reg;
  logic signed [DOT_W-1:0]  thresh_reg;

  logic [5:0]               beat_pop;
  logic                     beat_fire;
  logic                     last_beat;
  logic [NW_W-1:0]          n_sat;
  logic [ACC_W-1:0]         acc_sum;
  logic [DOT_W-1:0]         two_acc;
  logic [DOT_W-1:0]         n_x32;
  logic signed [DOT_W-1:0]  dot_sum;
  logic                     zero_act;

  bnn_xnor_popcount u_pop (
    .a   (op_a_i),
    .b   (op_b_i),
    .cnt (beat_pop)
  );

  assign op_ready_o = (state == RUN);
  assign busy_o     = (state != IDLE);
  assign beat_fire  = op_ready_o && op_valid_i;
  assign last_beat  = (beat_cnt == n_reg - NW_W'(1));

  assign n_sat = (num_words_i > NW_W'(MAX_WORDS)) ? NW_W'(MAX_WORDS) : num_words_i;

  // Result of the final beat is formed from the post-accumulation value so the
  // outputs can be registered on entry to DONE and held there untouched.
  assign acc_sum  = acc + ACC_W'(beat_pop);
  assign two_acc  = {1'b0, acc_sum, 1'b0};
  assign n_x32    = DOT_W'({n_reg, 5'b0});
  assign dot_sum  = $signed(two_acc - n_x32);

  // An empty vector has dot 0, so the activation reduces to thresh <= 0.
  assign zero_act = thresh_i[DOT_W-1] || (thresh_i == '0);

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      beat_cnt    <= '0;
      n_reg       <= '0;
      thresh_reg  <= '0;
      res_valid_o <= 1'b0;
      res_dot_o   <= '0;
      res_act_o   <= 1'b0;
      res_cnt_o   <= '0;
    end else if (abort_i) begin
      state       <= IDLE;
      acc         <= '0;
      beat_cnt    <= '0;
      res_valid_o <= 1'b0;
      res_dot_o   <= '0;
      res_act_o   <= 1'b0;
      res_cnt_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            n_reg      <= n_sat;
            thresh_reg <= thresh_i;
            acc        <= '0;
            beat_cnt   <= '0;
            if (n_sat == '0) begin
              state       <= DONE;
              res_valid_o <= 1'b1;
              res_dot_o   <= '0;
              res_act_o   <= zero_act;
              res_cnt_o   <= '0;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (beat_fire) begin
            acc      <= acc_sum;
            beat_cnt <= beat_cnt + NW_W'(1);
            if (last_beat) begin
              state       <= DONE;
              res_valid_o <= 1'b1;
              res_dot_o   <= dot_sum;
              res_act_o   <= (dot_sum >= thresh_reg);
              res_cnt_o   <= acc_sum;
            end
          end
        end

        DONE: begin
          if (res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            res_dot_o   <= '0;
            res_act_o   <= 1'b0;
            res_cnt_o   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Directed + randomized bench for bnn_neuron_seq, checked against an arithmetic
// model of the binarized dot product built from queues of operand words.

module tb_bnn_neuron_seq;

  localparam int MAX_WORDS = 16;
  localparam int NW_W      = $clog2(MAX_WORDS + 1);
  localparam int ACC_W     = $clog2(32 * MAX_WORDS + 1);
  localparam int DOT_W     = ACC_W + 2;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic [NW_W-1:0]         num_words;
  logic signed [DOT_W-1:0] thresh;
  logic                    abort;
  logic                    op_valid;
  logic                    op_ready;
  logic [31:0]             op_a;
  logic [31:0]             op_b;
  logic                    busy;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [DOT_W-1:0] res_dot;
  logic                    res_act;
  logic [ACC_W-1:0]        res_cnt;

  bnn_neuron_seq #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .num_words_i (num_words),
    .thresh_i    (thresh),
    .abort_i     (abort),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .busy_o      (busy),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_dot_o   (res_dot),
    .res_act_o   (res_act),
    .res_cnt_o   (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  int          gap_q[$];

  always @(posedge clk) begin
    if (rst_n && op_valid && op_ready && !abort) hs_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n_raw, input int th);
    start     = 1'b1;
    num_words = NW_W'(n_raw);
    thresh    = DOT_W'(th);
    tick();
    start     = 1'b0;
  endtask

  task automatic send_beat(input string tag, input logic [31:0] a, input logic [31:0] b);
    int w;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    w        = 0;
    while (op_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) check({tag, " ready timeout"}, 0, 1);
    tick();
    op_valid = 1'b0;
  endtask

  // mode 0 random, 1 a==b, 2 a=0/b=ones, 3 a^b=0000FFFF, 4 a=b=ones
  task automatic fill(input int n, input int mode);
    logic [31:0] r;
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      case (mode)
        1:       begin a_q.push_back(r);            b_q.push_back(r);                   end
        2:       begin a_q.push_back(32'h0);        b_q.push_back(32'hFFFF_FFFF);       end
        3:       begin a_q.push_back(r);            b_q.push_back(r ^ 32'h0000_FFFF);   end
        4:       begin a_q.push_back(32'hFFFF_FFFF); b_q.push_back(32'hFFFF_FFFF);      end
        default: begin a_q.push_back(r);            b_q.push_back($urandom);            end
      endcase
    end
  endtask

  // Full transaction: start, stream the queued words, check result, optionally hold, consume.
  task automatic run_op(input string tag, input int n_raw, input int th, input int max_gap,
                        input int hold, input int pulse_at);
    int n;
    int exp_cnt;
    int exp_dot;
    int exp_act;
    int gap;
    n       = (n_raw > MAX_WORDS) ? MAX_WORDS : n_raw;
    exp_cnt = 0;
    for (int i = 0; i < n; i++) exp_cnt += $countones(~(a_q[i] ^ b_q[i]));
    exp_dot = 2 * exp_cnt - 32 * n;
    exp_act = (exp_dot >= th) ? 1 : 0;

    do_start(n_raw, th);
    check({tag, " busy after start"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      gap = (gap_q.size() > 0) ? gap_q.pop_front() : int'($urandom_range(0, max_gap));
      repeat (gap) tick();
      if (i == pulse_at) begin
        start     = 1'b1;
        num_words = NW_W'(2);
        thresh    = DOT_W'(700);
      end
      send_beat(tag, a_q[i], b_q[i]);
      start = 1'b0;
    end
    check({tag, " res_valid latency"}, res_valid, 1);
    check({tag, " res_cnt"}, res_cnt, exp_cnt);
    check({tag, " res_dot"}, res_dot, exp_dot);
    check({tag, " res_act"}, res_act, exp_act);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, " hold valid"}, res_valid, 1);
      check({tag, " hold dot"}, res_dot, exp_dot);
      check({tag, " hold cnt"}, res_cnt, exp_cnt);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle valid"}, res_valid, 0);
    check({tag, " idle dot"}, res_dot, 0);
  endtask

  initial begin
    int base;
    int seen;
    int n;
    int th;

    rst_n     = 1'b0;
    start     = 1'b0;
    num_words = '0;
    thresh    = '0;
    abort     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset op_ready", op_ready, 0);
    check("reset res_valid", res_valid, 0);
    check("reset res_cnt", res_cnt, 0);
    check("reset res_dot", res_dot, 0);
    check("reset res_act", res_act, 0);
    rst_n = 1'b1;
    tick();

    fill(1, 4);
    run_op("t1 single", 1, 0, 0, 0, -1);

    fill(4, 2);
    run_op("t2 th-128", 4, -128, 1, 0, -1);
    fill(4, 2);
    run_op("t2 th-127", 4, -127, 1, 0, -1);

    gap_q = '{0, 2, 1};
    fill(3, 3);
    base = hs_count;
    run_op("t3 gaps", 3, 0, 0, 0, -1);
    op_valid = 1'b1;
    tick();
    tick();
    op_valid = 1'b0;
    check("t3 beats accepted", hs_count - base, 3);

    a_q.delete();
    b_q.delete();
    run_op("t4 n0 th1", 0, 1, 0, 5, -1);
    run_op("t4 n0 th0", 0, 0, 0, 2, -1);

    fill(16, 1);
    run_op("t5 full", 16, int'($urandom_range(0, 600)), 1, 0, 5);
    fill(16, 0);
    run_op("sat n31", 31, 0, 1, 0, -1);

    for (int k = 0; k < 6; k++) begin
      n  = int'($urandom_range(1, MAX_WORDS));
      th = int'($urandom_range(0, 1200)) - 600;
      fill(n, int'($urandom_range(0, 3)));
      run_op("rand", n, th, 2, int'($urandom_range(0, 2)), -1);
    end

    fill(4, 0);
    do_start(4, 0);
    send_beat("t6 abort", a_q[0], b_q[0]);
    send_beat("t6 abort", a_q[1], b_q[1]);
    op_valid = 1'b1;
    op_a     = 32'h1234_5678;
    op_b     = 32'h1234_5678;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    op_valid = 1'b0;
    check("t6 abort busy", busy, 0);
    check("t6 abort valid", res_valid, 0);
    check("t6 abort cnt", res_cnt, 0);

    fill(2, 1);
    run_op("t6 after abort", 2, 0, 1, 0, -1);

    abort     = 1'b1;
    start     = 1'b1;
    num_words = NW_W'(3);
    tick();
    abort     = 1'b0;
    start     = 1'b0;
    check("t6 abort+start busy", busy, 0);

    do_start(0, 0);
    check("t6 done valid", res_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6 abort in done valid", res_valid, 0);
    check("t6 abort in done busy", busy, 0);

    fill(4, 1);
    do_start(4, 0);
    send_beat("t6 reset", a_q[0], b_q[0]);
    send_beat("t6 reset", a_q[1], b_q[1]);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 reset busy", busy, 0);
    check("t6 reset valid", res_valid, 0);
    check("t6 reset cnt", res_cnt, 0);
    tick();
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      tick();
      if (res_valid !== 1'b0) seen++;
    end
    check("t6 no valid after reset", seen, 0);

    fill(3, 0);
    run_op("t6 recovery", 3, -20, 1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
